// File: rtl/draw_board_grid_pkg.sv
// Shared constants for the brick-field renderer: default colours, brick geometry, VGA sizes.
// Also provides the edge-position helper used by the hit decode.
package draw_board_grid_pkg;

    localparam int unsigned H_SIZE = 800;
    localparam int unsigned V_SIZE = 600;

    localparam logic [11:0] DEF_BG_COLOR    = 12'h888;
    localparam logic [11:0] DEF_FLASH_COLOR = 12'hfff;

    localparam int unsigned DEF_X0       = 112;
    localparam int unsigned DEF_Y0       = 60;
    localparam int unsigned DEF_B_WIDTH  = 128;
    localparam int unsigned DEF_B_HEIGHT = 40;
    localparam int unsigned DEF_GAP_X    = 16;
    localparam int unsigned DEF_GAP_Y    = 16;

    localparam int unsigned IDX_W = 3;

    function automatic logic [11:0] edge_lo(input int unsigned origin, input int unsigned idx,
                                            input int unsigned size, input int unsigned gap);
        return 12'(origin + idx * (size + gap));
    endfunction

endpackage

// File: rtl/draw_board_grid_board_flash_timer.sv
// Per-brick flash down-counter: loads on destruction, clears on restore, counts frame ticks.
module board_flash_timer #(
    parameter logic [7:0] LOAD_VALUE = 8'd8
) (
    input  logic pclk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic tick,
    output logic active
);

    logic [7:0] count;

    always_ff @(posedge pclk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (tick && count != '0) begin
            count <= count - 8'd1;
        end
    end

    assign active = (count != '0);

endmodule

// File: rtl/draw_board_grid.sv
// Brick-grid renderer over VGA timing: frame-shadowed brick map, per-brick flash, 2-clock pipeline.
module draw_board_grid
    import draw_board_grid_pkg::*;
#(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLS         = 4,
    parameter int unsigned X0           = DEF_X0,
    parameter int unsigned Y0           = DEF_Y0,
    parameter int unsigned B_WIDTH      = DEF_B_WIDTH,
    parameter int unsigned B_HEIGHT     = DEF_B_HEIGHT,
    parameter int unsigned GAP_X        = DEF_GAP_X,
    parameter int unsigned GAP_Y        = DEF_GAP_Y,
    parameter logic [12*ROWS-1:0] ROW_COLORS = {12'hf22, 12'hfa2, 12'h2f2, 12'h22f},
    parameter logic [11:0] BG_COLOR     = DEF_BG_COLOR,
    parameter logic [11:0] FLASH_COLOR  = DEF_FLASH_COLOR,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic [10:0]          hcount_in,
    input  logic                 hsync_in,
    input  logic                 hblnk_in,
    input  logic [10:0]          vcount_in,
    input  logic                 vsync_in,
    input  logic                 vblnk_in,
    input  logic [ROWS*COLS-1:0] blocks_in,
    output logic [10:0]          hcount_out,
    output logic                 hsync_out,
    output logic                 hblnk_out,
    output logic [10:0]          vcount_out,
    output logic                 vsync_out,
    output logic                 vblnk_out,
    output logic [ROWS*COLS-1:0] blocks_out,
    output logic                 cleared_out,
    output logic [11:0]          rgb_out
);

    localparam int unsigned N = ROWS * COLS;

    logic         vblnk_q;
    logic         tick;
    logic [N-1:0] shadow;
    logic [N-1:0] active;

    always_ff @(posedge pclk) begin
        if (reset) vblnk_q <= 1'b0;
        else       vblnk_q <= vblnk_in;
    end

    assign tick = vblnk_in & ~vblnk_q;

    always_ff @(posedge pclk) begin
        if (reset)     shadow <= '0;
        else if (tick) shadow <= blocks_in;
    end

    // Counters compare the old shadow against the incoming map to see which edge each brick takes.
    for (genvar i = 0; i < N; i++) begin : g_timer
        board_flash_timer #(.LOAD_VALUE(8'(FLASH_FRAMES))) u_timer (
            .pclk   (pclk),
            .reset  (reset),
            .load   (tick & ~shadow[i] &  blocks_in[i]),
            .clear  (tick &  shadow[i] & ~blocks_in[i]),
            .tick   (tick),
            .active (active[i])
        );
    end

    logic [11:0]     hx, vy;
    logic [COLS-1:0] col_hit;
    logic [ROWS-1:0] row_hit;

    assign hx = {1'b0, hcount_in};
    assign vy = {1'b0, vcount_in};

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam logic [11:0] LO = edge_lo(X0, c, B_WIDTH, GAP_X);
        localparam logic [11:0] HI = LO + 12'(B_WIDTH - 1);
        assign col_hit[c] = (hx >= LO) && (hx <= HI);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam logic [11:0] LO = edge_lo(Y0, r, B_HEIGHT, GAP_Y);
        localparam logic [11:0] HI = LO + 12'(B_HEIGHT - 1);
        assign row_hit[r] = (vy >= LO) && (vy <= HI);
    end

    logic [IDX_W-1:0] col_idx, row_idx;

    always_comb begin
        col_idx = '0;
        row_idx = '0;
        for (int unsigned c = 0; c < COLS; c++) if (col_hit[c]) col_idx = IDX_W'(c);
        for (int unsigned r = 0; r < ROWS; r++) if (row_hit[r]) row_idx = IDX_W'(r);
    end

    logic [10:0]      hcount_s1, vcount_s1;
    logic             hsync_s1, hblnk_s1, vsync_s1, vblnk_s1, hit_s1;
    logic [IDX_W-1:0] col_s1, row_s1;

    always_ff @(posedge pclk) begin
        if (reset) begin
            hcount_s1 <= '0;
            vcount_s1 <= '0;
            hsync_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            vsync_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            hit_s1    <= 1'b0;
            col_s1    <= '0;
            row_s1    <= '0;
        end else begin
            hcount_s1 <= hcount_in;
            vcount_s1 <= vcount_in;
            hsync_s1  <= hsync_in;
            hblnk_s1  <= hblnk_in;
            vsync_s1  <= vsync_in;
            vblnk_s1  <= vblnk_in;
            hit_s1    <= (|col_hit) & (|row_hit);
            col_s1    <= col_idx;
            row_s1    <= row_idx;
        end
    end

    logic        sel_shadow, sel_active;
    logic [11:0] row_color, rgb_next;

    always_comb begin
        sel_shadow = 1'b0;
        sel_active = 1'b0;
        row_color  = BG_COLOR;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_s1 == IDX_W'(r)) row_color = ROW_COLORS[r*12 +: 12];
            for (int unsigned c = 0; c < COLS; c++) begin
                if (row_s1 == IDX_W'(r) && col_s1 == IDX_W'(c)) begin
                    sel_shadow = shadow[r*COLS + c];
                    sel_active = active[r*COLS + c];
                end
            end
        end

        if (hblnk_s1 || vblnk_s1) rgb_next = '0;
        else if (!hit_s1)         rgb_next = BG_COLOR;
        else if (!sel_shadow)     rgb_next = row_color;
        else if (sel_active)      rgb_next = FLASH_COLOR;
        else                      rgb_next = BG_COLOR;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vsync_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            rgb_out     <= '0;
            blocks_out  <= '0;
            cleared_out <= 1'b0;
        end else begin
            hcount_out  <= hcount_s1;
            vcount_out  <= vcount_s1;
            hsync_out   <= hsync_s1;
            hblnk_out   <= hblnk_s1;
            vsync_out   <= vsync_s1;
            vblnk_out   <= vblnk_s1;
            rgb_out     <= rgb_next;
            blocks_out  <= shadow;
            cleared_out <= (&shadow) & ~(|active);
        end
    end

endmodule
